// File: rtl/mc_ctrl.sv
// Multi-cycle controller FSM: IF/ID/EX/MEM/WB sequencing for the datapath.
// Define MC_CTRL_MEM_WAIT_EN to add mem_ready and stretch MEM until it is high.
module mc_ctrl #(
    parameter int STATE_W = 3
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [5:0]         op,
    input  logic [5:0]         funct,
    input  logic               zero,
`ifdef MC_CTRL_MEM_WAIT_EN
    input  logic               mem_ready,
`endif
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               reg_write,
    output logic               mem_write,
    output logic               s_num_write,
    output logic               s_b,
    output logic               s_ext,
    output logic               s_data_write,
    output logic [3:0]         aluop,
    output logic [STATE_W-1:0] state,
    output logic               done,
    output logic               illegal
);

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic [STATE_W-1:0] {
        S_IF  = STATE_W'(0),
        S_ID  = STATE_W'(1),
        S_EX  = STATE_W'(2),
        S_MEM = STATE_W'(3),
        S_WB  = STATE_W'(4)
    } state_t;

    state_t state_q, state_d;

    logic       ready;
    logic       r_ok;
    logic [3:0] r_alu;
    logic       is_r, is_ialu, is_ori, is_lw, is_sw, is_beq, is_j;
    logic       legal;
    logic [3:0] ex_alu;
    logic       ex_s_b, ex_s_ext;

    logic       pc_write_c, ir_write_c, reg_write_c, mem_write_c;
    logic [1:0] pc_src_c;
    logic       s_num_write_c, s_b_c, s_ext_c, s_data_write_c;
    logic [3:0] aluop_c;
    logic       done_c, illegal_c;

`ifdef MC_CTRL_MEM_WAIT_EN
    assign ready = mem_ready;
`else
    assign ready = 1'b1;
`endif

    always_comb begin
        r_ok  = 1'b1;
        r_alu = ALU_ADD;
        case (funct)
            6'b100001: r_alu = ALU_ADD;
            6'b100011: r_alu = ALU_SUB;
            6'b100100: r_alu = ALU_AND;
            6'b100101: r_alu = ALU_OR;
            6'b101010: r_alu = ALU_SLT;
            default:   r_ok  = 1'b0;
        endcase
    end

    assign is_r    = (op == OP_R) && r_ok;
    assign is_ialu = (op == OP_ADDI) || (op == OP_ADDIU);
    assign is_ori  = (op == OP_ORI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_j    = (op == OP_J);
    assign legal   = is_r | is_ialu | is_ori | is_lw | is_sw | is_beq | is_j;

    // ALU setup chosen in EX and held through MEM/WB so operands stay stable.
    always_comb begin
        ex_alu = ALU_ADD;
        unique case (1'b1)
            is_r:    ex_alu = r_alu;
            is_ori:  ex_alu = ALU_OR;
            is_beq:  ex_alu = ALU_SUB;
            default: ex_alu = ALU_ADD;
        endcase
    end

    assign ex_s_b   = is_ialu | is_ori | is_lw | is_sw;
    assign ex_s_ext = is_ialu | is_lw | is_sw;

    always_comb begin
        state_d        = state_q;
        pc_write_c     = 1'b0;
        pc_src_c       = 2'b00;
        ir_write_c     = 1'b0;
        reg_write_c    = 1'b0;
        mem_write_c    = 1'b0;
        s_num_write_c  = 1'b0;
        s_b_c          = 1'b0;
        s_ext_c        = 1'b0;
        s_data_write_c = 1'b0;
        aluop_c        = ALU_ADD;
        done_c         = 1'b0;
        illegal_c      = 1'b0;
        unique case (state_q)
            S_IF: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                state_d    = S_ID;
            end
            S_ID: begin
                if (is_j) begin
                    pc_write_c = 1'b1;
                    pc_src_c   = 2'b10;
                    done_c     = 1'b1;
                    state_d    = S_IF;
                end else if (!legal) begin
                    illegal_c = 1'b1;
                    done_c    = 1'b1;
                    state_d   = S_IF;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                aluop_c = ex_alu;
                s_b_c   = ex_s_b;
                s_ext_c = ex_s_ext;
                if (is_beq) begin
                    pc_write_c = zero;
                    pc_src_c   = {1'b0, zero};
                    done_c     = 1'b1;
                    state_d    = S_IF;
                end else if (is_lw || is_sw) begin
                    state_d = S_MEM;
                end else if (is_r || is_ialu || is_ori) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                aluop_c = ex_alu;
                s_b_c   = ex_s_b;
                s_ext_c = ex_s_ext;
                if (is_sw) begin
                    mem_write_c = 1'b1;
                    if (ready) begin
                        done_c  = 1'b1;
                        state_d = S_IF;
                    end
                end else if (is_lw) begin
                    if (ready) state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_WB: begin
                aluop_c        = ex_alu;
                s_b_c          = ex_s_b;
                s_ext_c        = ex_s_ext;
                reg_write_c    = 1'b1;
                s_num_write_c  = is_r;
                s_data_write_c = is_lw;
                done_c         = 1'b1;
                state_d        = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IF;
        else        state_q <= state_d;
    end

    // Reset forces every output low, including the debug state.
    assign pc_write     = reset & pc_write_c;
    assign pc_src       = reset ? pc_src_c : 2'b00;
    assign ir_write     = reset & ir_write_c;
    assign reg_write    = reset & reg_write_c;
    assign mem_write    = reset & mem_write_c;
    assign s_num_write  = reset & s_num_write_c;
    assign s_b          = reset & s_b_c;
    assign s_ext        = reset & s_ext_c;
    assign s_data_write = reset & s_data_write_c;
    assign aluop        = reset ? aluop_c : 4'b0000;
    assign state        = reset ? state_q : '0;
    assign done         = reset & done_c;
    assign illegal      = reset & illegal_c;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed vector table, corner sequences, and
// randomized instruction streams checked against a per-instruction model.
module tb_mc_ctrl;

    typedef struct packed {
        logic [2:0] st;
        logic       pw;
        logic [1:0] ps;
        logic       irw;
        logic       rw;
        logic       mw;
        logic       snw;
        logic       sb;
        logic       se;
        logic       sdw;
        logic [3:0] alu;
        logic       dn;
        logic       ill;
    } outs_t;

    typedef struct {
        string      nm;
        logic       rst;
        logic [5:0] op;
        logic [5:0] funct;
        logic       zero;
        outs_t      exp;
    } vec_t;

    typedef enum {C_R, C_ADDI, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_ILL} cls_t;

    localparam logic Y = 1'b1;
    localparam logic N = 1'b0;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
`ifdef MC_CTRL_MEM_WAIT_EN
    logic       mem_ready = 1'b1;
`endif

    logic       pc_write, ir_write, reg_write, mem_write;
    logic [1:0] pc_src;
    logic       s_num_write, s_b, s_ext, s_data_write;
    logic [3:0] aluop;
    logic [2:0] state;
    logic       done, illegal;
    outs_t      act;

    int checks = 0;
    int errors = 0;
    vec_t tbl[$];

    mc_ctrl #(.STATE_W(3)) dut (
        .clock(clock),
        .reset(reset),
        .op(op),
        .funct(funct),
        .zero(zero),
`ifdef MC_CTRL_MEM_WAIT_EN
        .mem_ready(mem_ready),
`endif
        .pc_write(pc_write),
        .pc_src(pc_src),
        .ir_write(ir_write),
        .reg_write(reg_write),
        .mem_write(mem_write),
        .s_num_write(s_num_write),
        .s_b(s_b),
        .s_ext(s_ext),
        .s_data_write(s_data_write),
        .aluop(aluop),
        .state(state),
        .done(done),
        .illegal(illegal)
    );

    assign act = {state, pc_write, pc_src, ir_write, reg_write, mem_write,
                  s_num_write, s_b, s_ext, s_data_write, aluop, done, illegal};

    always #5 clock = ~clock;

    function automatic outs_t mk(input logic [2:0] st, input logic pw,
                                 input logic [1:0] ps, input logic irw,
                                 input logic rw, input logic mw,
                                 input logic snw, input logic sb,
                                 input logic se, input logic sdw,
                                 input logic [3:0] alu, input logic dn,
                                 input logic ill);
        return {st, pw, ps, irw, rw, mw, snw, sb, se, sdw, alu, dn, ill};
    endfunction

    function automatic void add(input string nm, input logic r,
                                input logic [5:0] o, input logic [5:0] f,
                                input logic z, input outs_t e);
        vec_t v;
        v.nm = nm; v.rst = r; v.op = o; v.funct = f; v.zero = z; v.exp = e;
        tbl.push_back(v);
    endfunction

    // Reference model: instruction class, its state path, and per-step outputs.
    function automatic cls_t classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b000000:
                if (f inside {6'b100001, 6'b100011, 6'b100100,
                              6'b100101, 6'b101010}) return C_R;
                else return C_ILL;
            6'b001000, 6'b001001: return C_ADDI;
            6'b001101: return C_ORI;
            6'b100011: return C_LW;
            6'b101011: return C_SW;
            6'b000100: return C_BEQ;
            6'b000010: return C_J;
            default:   return C_ILL;
        endcase
    endfunction

    function automatic int path_len(input cls_t c);
        case (c)
            C_J, C_ILL: return 2;
            C_BEQ:      return 3;
            C_LW:       return 5;
            default:    return 4;
        endcase
    endfunction

    function automatic int state_at(input cls_t c, input int k);
        if (k <= 2) return k;
        if (k == 3) return (c == C_LW || c == C_SW) ? 3 : 4;
        return 4;
    endfunction

    function automatic logic [3:0] alu_of(input cls_t c, input logic [5:0] f);
        if (c == C_R) begin
            case (f)
                6'b100011: return 4'd1;
                6'b100100: return 4'd2;
                6'b100101: return 4'd3;
                6'b101010: return 4'd4;
                default:   return 4'd0;
            endcase
        end
        if (c == C_ORI) return 4'd3;
        if (c == C_BEQ) return 4'd1;
        return 4'd0;
    endfunction

    function automatic outs_t model(input logic [5:0] o, input logic [5:0] f,
                                    input logic z, input int k);
        outs_t e;
        cls_t  c;
        int    s;
        c = classify(o, f);
        s = state_at(c, k);
        e = '0;
        e.st = 3'(s);
        e.dn = (k == path_len(c) - 1);
        if (s == 0) begin
            e.irw = 1'b1;
            e.pw  = 1'b1;
        end else if (s == 1) begin
            if (c == C_J) begin
                e.pw = 1'b1;
                e.ps = 2'b10;
            end
            e.ill = (c == C_ILL);
        end else begin
            e.alu = alu_of(c, f);
            e.sb  = (c == C_ADDI || c == C_ORI || c == C_LW || c == C_SW);
            e.se  = (c == C_ADDI || c == C_LW || c == C_SW);
            if (s == 2 && c == C_BEQ && z) begin
                e.pw = 1'b1;
                e.ps = 2'b01;
            end
            if (s == 3) e.mw = (c == C_SW);
            if (s == 4) begin
                e.rw  = 1'b1;
                e.snw = (c == C_R);
                e.sdw = (c == C_LW);
            end
        end
        return e;
    endfunction

    task automatic cyc(input string nm, input logic r, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input outs_t e);
        @(negedge clock);
        reset = r;
        op    = o;
        funct = f;
        zero  = z;
        #1;
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s: got %h want %h", nm, act, e);
        end
    endtask

    initial begin
        outs_t z0, ifv, idv, ex_mem, mem_ld, mem_sw;
        logic [5:0] ro, rf;
        logic [5:0] rfun[5];
        cls_t rc;
        int   n;

        z0     = '0;
        ifv    = mk(3'd0, Y, 2'd0, Y, N, N, N, N, N, N, 4'd0, N, N);
        idv    = mk(3'd1, N, 2'd0, N, N, N, N, N, N, N, 4'd0, N, N);
        ex_mem = mk(3'd2, N, 2'd0, N, N, N, N, Y, Y, N, 4'd0, N, N);
        mem_ld = mk(3'd3, N, 2'd0, N, N, N, N, Y, Y, N, 4'd0, N, N);
        mem_sw = mk(3'd3, N, 2'd0, N, N, Y, N, Y, Y, N, 4'd0, Y, N);

        for (int i = 0; i < 3; i++) add("reset", N, 6'b100011, 6'd0, Y, z0);
        add("lw_if",  Y, 6'b100011, 6'd0, N, ifv);
        add("lw_id",  Y, 6'b100011, 6'd0, N, idv);
        add("lw_ex",  Y, 6'b100011, 6'd0, Y, ex_mem);
        add("lw_mem", Y, 6'b100011, 6'd0, N, mem_ld);
        add("lw_wb",  Y, 6'b100011, 6'd0, N,
            mk(3'd4, N, 2'd0, N, Y, N, N, Y, Y, Y, 4'd0, Y, N));
        add("sw_if",  Y, 6'b101011, 6'd0, N, ifv);
        add("sw_id",  Y, 6'b101011, 6'd0, N, idv);
        add("sw_ex",  Y, 6'b101011, 6'd0, N, ex_mem);
        add("sw_mem", Y, 6'b101011, 6'd0, N, mem_sw);
        add("addu_if", Y, 6'd0, 6'b100001, N, ifv);
        add("addu_id", Y, 6'd0, 6'b100001, N, idv);
        add("addu_ex", Y, 6'd0, 6'b100001, Y,
            mk(3'd2, N, 2'd0, N, N, N, N, N, N, N, 4'd0, N, N));
        add("addu_wb", Y, 6'd0, 6'b100001, N,
            mk(3'd4, N, 2'd0, N, Y, N, Y, N, N, N, 4'd0, Y, N));
        add("slt_if", Y, 6'd0, 6'b101010, N, ifv);
        add("slt_id", Y, 6'd0, 6'b101010, N, idv);
        add("slt_ex", Y, 6'd0, 6'b101010, N,
            mk(3'd2, N, 2'd0, N, N, N, N, N, N, N, 4'd4, N, N));
        add("slt_wb", Y, 6'd0, 6'b101010, N,
            mk(3'd4, N, 2'd0, N, Y, N, Y, N, N, N, 4'd4, Y, N));
        add("ori_if", Y, 6'b001101, 6'd0, N, ifv);
        add("ori_id", Y, 6'b001101, 6'd0, N, idv);
        add("ori_ex", Y, 6'b001101, 6'd0, N,
            mk(3'd2, N, 2'd0, N, N, N, N, Y, N, N, 4'd3, N, N));
        add("ori_wb", Y, 6'b001101, 6'd0, N,
            mk(3'd4, N, 2'd0, N, Y, N, N, Y, N, N, 4'd3, Y, N));
        add("beq1_if", Y, 6'b000100, 6'd0, Y, ifv);
        add("beq1_id", Y, 6'b000100, 6'd0, Y, idv);
        add("beq1_ex", Y, 6'b000100, 6'd0, Y,
            mk(3'd2, Y, 2'd1, N, N, N, N, N, N, N, 4'd1, Y, N));
        add("beq0_if", Y, 6'b000100, 6'd0, N, ifv);
        add("beq0_id", Y, 6'b000100, 6'd0, N, idv);
        add("beq0_ex", Y, 6'b000100, 6'd0, N,
            mk(3'd2, N, 2'd0, N, N, N, N, N, N, N, 4'd1, Y, N));
        add("j_if", Y, 6'b000010, 6'd0, N, ifv);
        add("j_id", Y, 6'b000010, 6'd0, N,
            mk(3'd1, Y, 2'd2, N, N, N, N, N, N, N, 4'd0, Y, N));
        add("ill_if", Y, 6'b111111, 6'd0, N, ifv);
        add("ill_id", Y, 6'b111111, 6'd0, N,
            mk(3'd1, N, 2'd0, N, N, N, N, N, N, N, 4'd0, Y, Y));
        add("illf_if", Y, 6'd0, 6'b000000, N, ifv);
        add("illf_id", Y, 6'd0, 6'b000000, N,
            mk(3'd1, N, 2'd0, N, N, N, N, N, N, N, 4'd0, Y, Y));
        add("after_ill", Y, 6'b100011, 6'd0, N, ifv);
        add("after_id", Y, 6'b100011, 6'd0, N, idv);
        add("after_ex", Y, 6'b100011, 6'd0, N, ex_mem);

        foreach (tbl[i])
            cyc(tbl[i].nm, tbl[i].rst, tbl[i].op, tbl[i].funct,
                tbl[i].zero, tbl[i].exp);
        cyc("mid_rst", N, 6'b100011, 6'd0, N, z0);

        // Reset taken while sw sits in MEM: no write, restart at IF.
        cyc("swr_if", Y, 6'b101011, 6'd0, N, ifv);
        cyc("swr_id", Y, 6'b101011, 6'd0, N, idv);
        cyc("swr_ex", Y, 6'b101011, 6'd0, N, ex_mem);
        cyc("swr_rst", N, 6'b101011, 6'd0, N, z0);
        cyc("swr_rel", Y, 6'b101011, 6'd0, N, ifv);
        cyc("swr_id2", Y, 6'b101011, 6'd0, N, idv);
        cyc("swr_ex2", Y, 6'b101011, 6'd0, N, ex_mem);
        cyc("swr_mem", Y, 6'b101011, 6'd0, N, mem_sw);

`ifdef MC_CTRL_MEM_WAIT_EN
        cyc("wsw_if", Y, 6'b101011, 6'd0, N, ifv);
        cyc("wsw_id", Y, 6'b101011, 6'd0, N, idv);
        cyc("wsw_ex", Y, 6'b101011, 6'd0, N, ex_mem);
        mem_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("wsw_hold", Y, 6'b101011, 6'd0, N,
                mk(3'd3, N, 2'd0, N, N, Y, N, Y, Y, N, 4'd0, N, N));
        mem_ready = 1'b1;
        cyc("wsw_mem", Y, 6'b101011, 6'd0, N, mem_sw);
        cyc("wlw_if", Y, 6'b100011, 6'd0, N, ifv);
        cyc("wlw_id", Y, 6'b100011, 6'd0, N, idv);
        cyc("wlw_ex", Y, 6'b100011, 6'd0, N, ex_mem);
        mem_ready = 1'b0;
        cyc("wlw_hold", Y, 6'b100011, 6'd0, N, mem_ld);
        mem_ready = 1'b1;
        cyc("wlw_mem", Y, 6'b100011, 6'd0, N, mem_ld);
        cyc("wlw_wb", Y, 6'b100011, 6'd0, N,
            mk(3'd4, N, 2'd0, N, Y, N, N, Y, Y, Y, 4'd0, Y, N));
        cyc("wr_if", Y, 6'b101011, 6'd0, N, ifv);
        cyc("wr_id", Y, 6'b101011, 6'd0, N, idv);
        cyc("wr_ex", Y, 6'b101011, 6'd0, N, ex_mem);
        mem_ready = 1'b0;
        cyc("wr_hold", Y, 6'b101011, 6'd0, N,
            mk(3'd3, N, 2'd0, N, N, Y, N, Y, Y, N, 4'd0, N, N));
        cyc("wr_rst", N, 6'b101011, 6'd0, N, z0);
        mem_ready = 1'b1;
        cyc("wr_rel", Y, 6'b101011, 6'd0, N, ifv);
        cyc("wr_id2", Y, 6'b101011, 6'd0, N, idv);
        cyc("wr_ex2", Y, 6'b101011, 6'd0, N, ex_mem);
        cyc("wr_mem", Y, 6'b101011, 6'd0, N, mem_sw);
`endif

        rfun[0] = 6'b100001; rfun[1] = 6'b100011; rfun[2] = 6'b100100;
        rfun[3] = 6'b100101; rfun[4] = 6'b101010;
        for (int t = 0; t < 400; t++) begin
            rf = 6'($urandom_range(0, 63));
            case ($urandom_range(0, 9))
                0: begin ro = 6'd0; rf = rfun[$urandom_range(0, 4)]; end
                1: ro = 6'b001000;
                2: ro = 6'b001001;
                3: ro = 6'b001101;
                4: ro = 6'b100011;
                5: ro = 6'b101011;
                6: ro = 6'b000100;
                7: ro = 6'b000010;
                8: begin
                    ro = 6'($urandom_range(0, 63));
                    if (classify(ro, rf) != C_ILL) ro = 6'b111111;
                end
                default: begin
                    ro = 6'd0;
                    if (classify(ro, rf) != C_ILL) rf = 6'b000000;
                end
            endcase
            rc = classify(ro, rf);
            n = path_len(rc);
            for (int k = 0; k < n; k++) begin
                logic z;
                z = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 39) == 0) begin
                    cyc($sformatf("rnd_rst op=%b f=%b k=%0d", ro, rf, k),
                        N, ro, rf, z, z0);
                    break;
                end
                cyc($sformatf("rnd op=%b f=%b k=%0d", ro, rf, k),
                    Y, ro, rf, z, model(ro, rf, z, k));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle controller FSM that sequences the existing datapath blocks (pc, im, gpr, alu, dm, extend, mux2) over several cycles per instruction, replacing the single-cycle ctrl decode.
- Decodes op/funct from the instruction register and drives the write strobes, mux selects and aluop state by state.
- Sits beside the datapath and adds IR and PC write enables, which the datapath gates.

Parameters:
- STATE_W, 3, width of the state register and the state output.

Ports:
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low reset
- op  in  6  instruction[31:26] from IR
- funct  in  6  instruction[5:0] from IR
- zero  in  1  ALU result == 0
- pc_write  out  1  PC load enable
- pc_src  out  2  next-PC select: 00 PC+4, 01 branch target, 10 jump target
- ir_write  out  1  IR load enable
- reg_write  out  1  gpr write enable
- mem_write  out  1  dm write enable
- s_num_write  out  1  write-register select: 0 rt, 1 rd
- s_b  out  1  ALU B select: 0 gpr, 1 extended immediate
- s_ext  out  1  extend mode: 0 zero-extend, 1 sign-extend
- s_data_write  out  1  write-back select: 0 ALU, 1 dm
- aluop  out  4  0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 SLT
- state  out  STATE_W  current state, for debug
- done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal  out  1  one-cycle pulse in ID on an unsupported opcode or funct

Behaviour:
- States: IF=0, ID=1, EX=2, MEM=3, WB=4. Encodings 5–7 are unreachable; if entered, next state is IF with no strobes.
- Reset: when reset==0 at a clock edge, state<=IF. While reset==0, every output is 0 (state output reads 0). A reset mid-instruction abandons it with no further writes. The first cycle after release is IF.
- Outputs are combinational from state, op, funct and zero. Only one write strobe fires per cycle, apart from IF.
- IF:
  - ir_write=1, pc_write=1, pc_src=00.
  - Next state ID.
- ID:
  - Decode only.
  - j (000010): pc_write=1, pc_src=10, done=1, next IF. Total 2 cycles.
  - Unsupported op: illegal=1, done=1, next IF, no writes.
  - Otherwise next EX.
- EX:
  - R-type (op 000000), by funct: addu 100001→ADD, subu 100011→SUB, and 100100→AND, or 100101→OR, slt 101010→SLT; s_b=0; next WB. Any other funct is flagged illegal in ID.
  - addi 001000 and addiu 001001: ADD, s_b=1, s_ext=1, next WB.
  - ori 001101: OR, s_b=1, s_ext=0, next WB.
  - lw 100011 and sw 101011: ADD, s_b=1, s_ext=1, next MEM.
  - beq 000100: SUB, s_b=0. If zero=1, then pc_write=1 and pc_src=01. done=1, next IF. Total 3 cycles.
- MEM:
  - aluop and s_b are held at EX values so the address stays stable.
  - sw: mem_write=1, done=1, next IF. Total 4 cycles.
  - lw: next WB.
- WB:
  - reg_write=1, done=1, next IF. aluop, s_b and s_ext are held at EX values.
  - R-type: s_num_write=1, s_data_write=0.
  - I-ALU: s_num_write=0, s_data_write=0.
  - lw: s_num_write=0, s_data_write=1. R and I-ALU total 4 cycles; lw total 5.
- Selects not listed for a state are 0.
- op and funct must stay stable from the end of IF until the next IF. They come from the IR, which updates only on ir_write.
- Cycle counts are fixed; there is no dependence on data except beq's pc_write.

Optional Feature:
- MC_CTRL_MEM_WAIT_EN
  - Defined: adds input mem_ready (1 bit). In MEM, the state is held and mem_write is held high until mem_ready=1. MEM is exited on the cycle mem_ready=1, and done for sw pulses on that cycle. In WB for lw, s_data_write is asserted only after MEM has been exited. A reset while waiting returns to IF.
  - Undefined: no mem_ready port; MEM always lasts exactly one cycle.

Test Plan:
- Reset: hold reset=0 for 3 cycles with op=100011 → all outputs 0 and state=0. Release → next cycle state=0 with ir_write=1 and pc_write=1.
- addu (op 000000, funct 100001) → states 0,1,2,4. In EX, aluop=0000 and s_b=0. In WB, reg_write=1, s_num_write=1, done=1. 4 cycles.
- lw (100011) then sw (101011) → lw takes 5 cycles, with s_data_write=1 and reg_write=1 in WB. sw takes 4 cycles, with mem_write=1 only in MEM.
- beq (000100) with zero=1 → EX has pc_write=1 and pc_src=01. With zero=0 → EX has pc_write=0. done=1 in both cases; 3 cycles.
- j (000010) → ID has pc_write=1 and pc_src=10; 2 cycles. op=111111 → illegal=1 in ID, no strobes, back to IF.
- Reset asserted during the MEM state of sw → no mem_write on the following edge and state=0. With MC_CTRL_MEM_WAIT_EN and mem_ready low for 3 cycles → MEM held 4 cycles, mem_write high throughout.
